// File: rtl/onehot_codec_if.sv
// Handshake bundle between a producer/consumer pair and onehot_codec.
// The master side drives requests and accepts results; the slave side is the codec.
interface onehot_codec_if #(
   parameter int BIN_W = 4
);
   localparam int OH_W = 2 ** BIN_W;

   logic            mode;
   logic            in_valid;
   logic            in_ready;
   logic [OH_W-1:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [OH_W-1:0] out_data;
   logic            out_err;

   modport master (
      output mode,
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_err
   );

   modport slave (
      input  mode,
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_err
   );
endinterface

// File: rtl/onehot_codec.sv
// onehot_codec: per-transaction binary<->one-hot converter with a 2-entry
// result FIFO on a valid/ready handshake.
//   mode 0 : decode, in_data[BIN_W-1:0] -> one-hot vector
//   mode 1 : encode, one-hot vector -> index (lowest set bit), out_err when
//            the vector is zero or has more than one bit set
// BIN_W legal range is 1..8; OH_W = 2**BIN_W is derived, not a parameter.
// Optional build macro ONEHOT_CODEC_ERRCNT_EN adds a 16-bit saturating
// err_count of output transfers that carried out_err = 1.
// in_ready depends only on registered occupancy, so there is no
// combinational path from out_ready to in_ready; a full FIFO therefore
// refuses input even in a cycle where it is being drained.
module onehot_codec #(
   parameter int BIN_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   onehot_codec_if.slave  bus
`ifdef ONEHOT_CODEC_ERRCNT_EN
   ,
   output logic [15:0]    err_count
`else
`endif
);
   localparam int OH_W = 2 ** BIN_W;

   logic [OH_W-1:0]  w_dec_data;
   logic [BIN_W-1:0] w_enc_idx;
   logic             w_enc_zero;
   logic             w_enc_multi;
   logic [OH_W-1:0]  w_res_data;
   logic             w_res_err;

   logic [OH_W-1:0]  r_mem_data [2];
   logic [1:0]       r_mem_err;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             r_live;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_push;
   logic             w_pop;

   // Decode: set exactly the bit addressed by the low BIN_W bits of in_data.
   always_comb begin
      w_dec_data = '0;
      w_dec_data[bus.in_data[BIN_W-1:0]] = 1'b1;
   end

   // Encode: priority-select the lowest set bit; scanning downward lets the
   // lowest index overwrite any higher one.
   always_comb begin
      w_enc_idx = '0;
      for (int i = OH_W - 1; i >= 0; i--) begin
         if (bus.in_data[i]) begin
            w_enc_idx = BIN_W'(i);
         end
      end
   end

   // x & (x-1) clears the lowest set bit; anything left means multi-hot.
   assign w_enc_zero  = ~|bus.in_data;
   assign w_enc_multi = |(bus.in_data & (bus.in_data - OH_W'(1)));

   assign w_res_data = bus.mode ? OH_W'(w_enc_idx) : w_dec_data;
   assign w_res_err  = bus.mode & (w_enc_zero | w_enc_multi);

   // r_live holds in_ready low through reset and the first edge after it.
   assign w_in_ready  = r_live & (r_count != 2'd2);
   assign w_out_valid = (r_count != 2'd0);
   assign w_push      = bus.in_valid & w_in_ready;
   assign w_pop       = w_out_valid & bus.out_ready;

   // Result FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            r_mem_data[i] <= '0;
         end
         r_mem_err <= '0;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
         r_live    <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_res_data;
            r_mem_err[r_wr_ptr]  <= w_res_err;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   // Head is masked when empty so a stale slot never shows on the bus.
   assign bus.out_data  = w_out_valid ? r_mem_data[r_rd_ptr] : '0;
   assign bus.out_err   = w_out_valid & r_mem_err[r_rd_ptr];

`ifdef ONEHOT_CODEC_ERRCNT_EN
   logic [15:0] r_err_count;

   // Count errored output transfers, saturating at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_count <= 16'h0000;
      end else if (w_pop && r_mem_err[r_rd_ptr] && (r_err_count != 16'hFFFF)) begin
         r_err_count <= r_err_count + 16'h0001;
      end
   end

   assign err_count = r_err_count;
`else
`endif

endmodule

// File: tb/tb_onehot_codec.sv
// Directed bench for onehot_codec with a result scoreboard.
module tb_onehot_codec;
   localparam int BIN_W = 4;
   localparam int OH_W  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   onehot_codec_if #(.BIN_W(BIN_W)) ifc ();

`ifdef ONEHOT_CODEC_ERRCNT_EN
   logic [15:0] err_count;
   onehot_codec #(.BIN_W(BIN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (ifc),
      .err_count (err_count)
   );
`else
   onehot_codec #(.BIN_W(BIN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );
`endif

   int checks   = 0;
   int failures = 0;
   int n_acc    = 0;
   int n_pop    = 0;
   int err_seen = 0;
   logic [16:0] sb [$];
   logic [16:0] cur_exp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: {err, data}.
   function automatic logic [16:0] model(input logic m, input logic [15:0] d);
      logic [15:0] r;
      int          ones;
      int          first;
      r = 16'h0000;
      if (!m) begin
         r[d[3:0]] = 1'b1;
         return {1'b0, r};
      end
      ones  = $countones(d);
      first = -1;
      for (int i = 0; i < OH_W; i++) begin
         if (d[i] && first < 0) first = i;
      end
      if (first >= 0) r = 16'(first);
      return {(ones != 1), r};
   endfunction

   task automatic drive(input logic m, input logic [15:0] d, input logic [16:0] e);
      ifc.mode     = m;
      ifc.in_data  = d;
      cur_exp      = e;
      ifc.in_valid = 1'b1;
   endtask

   task automatic next_stim();
      logic        m;
      logic [15:0] d;
      m = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      if (m && ($urandom_range(0, 3) != 0)) begin
         d = 16'h0001 << $urandom_range(0, 15);
      end
      drive(m, d, model(m, d));
   endtask

   // One clock: sample at the falling edge, retire/record transfers, then
   // return 1 time unit after the rising edge. exp_ov < 0 skips the check.
   task automatic tick(input int exp_ov);
      logic [16:0] e;
      @(negedge clk);
      if (exp_ov >= 0) check("out_valid", 32'(ifc.out_valid), 32'(exp_ov));
      if (ifc.out_valid && ifc.out_ready) begin
         n_pop++;
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_data", 32'(ifc.out_data), 32'(e[15:0]));
            check("out_err", 32'(ifc.out_err), 32'(e[16]));
            if (e[16]) err_seen++;
         end
      end
      if (ifc.in_valid && ifc.in_ready) begin
         sb.push_back(cur_exp);
         n_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int budget;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      budget = 0;
      while (sb.size() != 0 && budget < 20) begin
         tick(-1);
         budget++;
      end
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc0;
      int          pop0;
      int          last_acc;
      logic [15:0] head;
      logic [15:0] d;
      logic [15:0] oh;

      ifc.mode      = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.out_ready = 1'b0;
      cur_exp       = '0;

      // Reset state
      #12;
      check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
      check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check("rst_out_data", 32'(ifc.out_data), 32'd0);
      check("rst_out_err", 32'(ifc.out_err), 32'd0);
`ifdef ONEHOT_CODEC_ERRCNT_EN
      check("rst_err_count", 32'(err_count), 32'd0);
`endif
      rst = 1'b0;
      #1;
      check("release_in_ready_pre", 32'(ifc.in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("release_in_ready_post", 32'(ifc.in_ready), 32'd1);

      // Decode sweep, back-to-back, upper in_data bits randomised
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         d       = 16'($urandom);
         d[3:0]  = 4'(i);
         oh      = 16'h0001 << i;
         drive(1'b0, d, {1'b0, oh});
         tick(i == 0 ? 0 : 1);
      end
      ifc.in_valid = 1'b0;
      tick(1);
      check("sweep_drained", 32'(sb.size()), 32'd0);
      tick(0);

      // Encode cases
      drive(1'b1, 16'h0400, {1'b0, 16'd10});
      tick(0);
      drive(1'b1, 16'h0000, {1'b1, 16'd0});
      tick(1);
      drive(1'b1, 16'h0C00, {1'b1, 16'd10});
      tick(1);
      ifc.in_valid = 1'b0;
      tick(1);
      tick(0);
`ifdef ONEHOT_CODEC_ERRCNT_EN
      check("err_count_encode", 32'(err_count), 32'(err_seen));
`endif

      // Mixed modes back-to-back
      drive(1'b0, 16'h0003, {1'b0, 16'h0008});
      tick(0);
      drive(1'b1, 16'h0008, {1'b0, 16'd3});
      tick(1);
      drive(1'b0, 16'h000F, {1'b0, 16'h8000});
      tick(1);
      ifc.in_valid = 1'b0;
      tick(1);
      tick(0);

      // Backpressure
      ifc.out_ready = 1'b0;
      acc0 = n_acc;
      pop0 = n_pop;
      head = '0;
      next_stim();
      for (int c = 0; c < 6; c++) begin
         last_acc = n_acc;
         tick(-1);
         if (c == 1) head = ifc.out_data;
         if (n_acc != last_acc) next_stim();
      end
      check("bp_accepted", 32'(n_acc - acc0), 32'd2);
      check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      check("bp_head_stable", 32'(ifc.out_data), 32'(head));
      ifc.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         last_acc = n_acc;
         tick(1);
         if (n_acc != last_acc) next_stim();
      end
      check("bp_resume_acc", 32'(n_acc - acc0), 32'd4);
      check("bp_resume_pop", 32'(n_pop - pop0), 32'd3);
      drain("bp_drained");
      tick(0);
`ifdef ONEHOT_CODEC_ERRCNT_EN
      check("err_count_bp", 32'(err_count), 32'(err_seen));
`endif

      // Reset mid-stream with two buffered entries
      ifc.out_ready = 1'b0;
      next_stim();
      tick(-1);
      next_stim();
      tick(-1);
      check("pre_rst_in_ready", 32'(ifc.in_ready), 32'd0);
      check("pre_rst_out_valid", 32'(ifc.out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(ifc.in_ready), 32'd0);
      check("mid_rst_out_data", 32'(ifc.out_data), 32'd0);
      check("mid_rst_out_err", 32'(ifc.out_err), 32'd0);
`ifdef ONEHOT_CODEC_ERRCNT_EN
      check("mid_rst_err_count", 32'(err_count), 32'd0);
`endif
      sb.delete();
      err_seen      = 0;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      @(negedge clk);
      check("rst_held_out_valid", 32'(ifc.out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rel2_in_ready_pre", 32'(ifc.in_ready), 32'd0);
      check("rel2_out_valid", 32'(ifc.out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("rel2_in_ready_post", 32'(ifc.in_ready), 32'd1);
      check("rel2_no_stale", 32'(ifc.out_valid), 32'd0);
      drive(1'b1, 16'h0000, {1'b1, 16'd0});
      tick(0);
      drive(1'b1, 16'h0030, {1'b1, 16'd4});
      tick(1);
      ifc.in_valid = 1'b0;
      tick(1);
      tick(0);
`ifdef ONEHOT_CODEC_ERRCNT_EN
      check("err_count_after_rst", 32'(err_count), 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/onehot_codec.md
ONEHOT_CODEC -- requirements
Module: onehot_codec

Interface
REQ-001 Parameter: BIN_W, default 4, binary index width; legal range 1..8.
REQ-002 Derived (not overridable): OH_W = 2**BIN_W, one-hot vector width (16 at default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mode  input  1  per-transaction operation: 0 = decode (binary->one-hot), 1 = encode (one-hot->binary).
REQ-006 in_valid  input  1  producer has a transaction on in_data/mode.
REQ-007 in_ready  output  1  block can accept a transaction this cycle.
REQ-008 in_data  input  OH_W  decode: index in bits [BIN_W-1:0], upper bits ignored; encode: one-hot vector.
REQ-009 out_valid  output  1  out_data/out_err hold a result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_data  output  OH_W  decode: one-hot vector; encode: index zero-extended to OH_W.
REQ-012 out_err  output  1  encode only: input not exactly one-hot; always 0 for decode.

Function
REQ-013 Transfer on input occurs when in_valid && in_ready at a rising edge; mode and in_data are sampled at that edge.
REQ-014 Transfer on output occurs when out_valid && out_ready at a rising edge.
REQ-015 Decode: out_data = exactly bit in_data[BIN_W-1:0] set, all others 0; every index 0..OH_W-1 is valid.
REQ-016 Encode, exactly one bit k set: out_data = k, out_err = 0.
REQ-017 Encode, two or more bits set: out_data = index of lowest set bit, out_err = 1.
REQ-018 Encode, all bits zero: out_data = 0, out_err = 1.
REQ-019 Results held in a 2-entry FIFO; order of output equals order of acceptance.
REQ-020 Latency: result of an accepted transaction with an empty FIFO appears at out_valid = 1 in the cycle after acceptance (1 cycle).
REQ-021 in_ready = 1 when FIFO occupancy < 2, purely from registered state (no combinational path from out_ready to in_ready).
REQ-022 Occupancy 2 with simultaneous output transfer: no input accepted that cycle (in_ready is 0); occupancy becomes 1.
REQ-023 Occupancy 1 with simultaneous input and output transfer: occupancy stays 1, new result becomes head next cycle; sustained throughput 1 transaction/cycle.
REQ-024 out_valid = 0 when occupancy 0; out_data/out_err of the head entry stable while out_valid && !out_ready.
REQ-025 Read/write pointers wrap modulo 2.
REQ-026 mode may change every transaction; no pipeline flush or bubble on mode change.

Reset
REQ-027 While rst = 1: occupancy 0, pointers 0, out_valid = 0, out_data = 0, out_err = 0, in_ready = 0.
REQ-028 in_ready rises to 1 on the first rising edge after rst deasserts.
REQ-029 Reset asserted mid-operation discards all buffered results immediately (asynchronously); no partial output is presented afterwards.

Configuration
REQ-030 Macro ONEHOT_CODEC_ERRCNT_EN defined: extra output err_count (output, 16 bits) counts output transfers with out_err = 1, saturates at 16'hFFFF, reset to 0 by rst.
REQ-031 Macro ONEHOT_CODEC_ERRCNT_EN undefined: err_count port and counter absent; all other behaviour identical.

Verification
REQ-032 Decode sweep, BIN_W=4, out_ready=1: in_data=0..15 back-to-back, mode=0 -> out_data=16'h0001, 16'h0002, ... 16'h8000 on consecutive cycles, each 1 cycle after acceptance, out_err=0.
REQ-033 Encode: 16'h0400 -> out_data=10, out_err=0; 16'h0000 -> out_data=0, out_err=1; 16'h0C00 -> out_data=10, out_err=1.
REQ-034 Backpressure: out_ready=0, in_valid=1 continuous -> exactly 2 accepted, in_ready=0 afterwards, head stable; out_ready=1 -> both drain in order, then acceptance resumes.
REQ-035 Mixed modes back-to-back: decode 3, encode 16'h0008, decode 15 -> 16'h0008, 3 (err 0), 16'h8000 in order.
REQ-036 Reset mid-stream with 2 buffered entries -> out_valid=0 during rst, no stale results after release; with ONEHOT_CODEC_ERRCNT_EN, err_count=0 after reset and increments once per errored output transfer.
